// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with a bounded hold time.
// Grants come out as a registered one-hot vector and a 2-bit index for the decoder select.
module rr_arb4 #(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid
);

    localparam int unsigned   CW      = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, state_n;
    logic [1:0]    ptr, ptr_n;
    logic [CW-1:0] hold_cnt, cnt_n;
    logic [1:0]    id_n;
    logic [3:0]    gnt_n;
    logic [3:0]    others;
    logic [2:0]    win;
    logic          timeout, rel;

    // Returns {found, index}: first set bit of r searching upward from s, wrapping mod 4.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] s);
        logic [1:0] k;
        pick = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            k = s + 2'(i);
            if (r[k] && !pick[2]) pick = {1'b1, k};
        end
    endfunction

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = hold_cnt;
        id_n    = gnt_id;
        others  = req & ~(4'b0001 << gnt_id);
        win     = '0;
        timeout = 1'b0;
        rel     = 1'b0;
        case (state)
            IDLE: begin
                win = pick(req, ptr);
                if (en && win[2]) begin
                    state_n = GRANT;
                    id_n    = win[1:0];
                    cnt_n   = '0;
                end
            end
            GRANT: begin
                // A lone holder never times out: timeout needs another requester waiting.
                timeout = (hold_cnt == CNT_MAX) && (|others);
                rel     = !en || !req[gnt_id] || timeout;
                win     = pick(others, gnt_id + 2'd1);
                if (rel) begin
                    ptr_n = gnt_id + 2'd1;
                    cnt_n = '0;
                    if (en && win[2]) begin
                        id_n = win[1:0];
                    end else begin
                        state_n = IDLE;
                        id_n    = '0;
                    end
                end else if (hold_cnt != CNT_MAX) begin
                    cnt_n = hold_cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        gnt_n = (state_n == GRANT) ? (4'b0001 << id_n) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt_id   <= '0;
            gnt      <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            hold_cnt <= cnt_n;
            gnt_id   <= id_n;
            gnt      <= gnt_n;
        end
    end

    assign gnt_valid = |gnt;

endmodule
